wta_classifier: RTL and testbench

- Parametrised winner-take-all output stage for the CSNN classification path; successor to the fixed 4-class, fixed-priority output decoder.
- On entry to the COMPLETE system state it snapshots the output-neuron membrane potentials and sums each class's neurons into a class score.
- It then scans the classes sequentially and drives an active-low one-hot class indicator, a class index and a one-cycle valid pulse.
- Below-threshold results report "no winner".

---
 rtl/wta_classifier.sv | 153 +++++++++++++++
 tb/tb_wta_classifier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wta_classifier.sv
// Winner-take-all classifier: snapshots output-neuron potentials on entry to
// COMPLETE, scans class scores one per cycle and registers the winner.
module wta_classifier #(
    parameter int unsigned NUM_CLASS      = 4,
    parameter int unsigned NEUR_PER_CLASS = 2,
    parameter int unsigned POT_W          = 3,
    parameter int unsigned MIN_SCORE      = 4,
    localparam int unsigned SCORE_W       = POT_W + $clog2(NEUR_PER_CLASS) + 1,
    localparam int unsigned IDX_W         = $clog2(NUM_CLASS),
    localparam int unsigned BUS_W         = NUM_CLASS * NEUR_PER_CLASS * POT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           system_state,
    input  logic [BUS_W-1:0]     potential_bus,
    output logic [NUM_CLASS-1:0] output_cls,
    output logic [IDX_W-1:0]     class_idx,
    output logic                 no_winner,
    output logic                 result_valid,
    output logic                 busy
);

    localparam int unsigned CLS_W = NEUR_PER_CLASS * POT_W;

    localparam logic [1:0] SYS_IDLE     = 2'b00;
    localparam logic [1:0] SYS_COMPLETE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           prev_state_q;
    logic [BUS_W-1:0]     snap_q, snap_d;
    logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [NUM_CLASS-1:0] output_cls_d;
    logic [IDX_W-1:0]     class_idx_d;
    logic                 no_winner_d;
    logic                 result_valid_d;
    logic                 busy_d;

    logic                 start_c;
    logic                 no_win_c;
    logic [CLS_W-1:0]     cls_slice_c;
    logic [SCORE_W-1:0]   score_c;

    // Fresh entry into COMPLETE; staying there does not retrigger
    assign start_c  = (system_state == SYS_COMPLETE) && (prev_state_q != SYS_COMPLETE);
    assign no_win_c = best_score_q < SCORE_W'(MIN_SCORE);

    // Score of the class currently addressed by the scan index
    always_comb begin
        cls_slice_c = '0;
        for (int unsigned c = 0; c < NUM_CLASS; c++) begin
            if (scan_idx_q == IDX_W'(c)) begin
                cls_slice_c = snap_q[c*CLS_W +: CLS_W];
            end
        end
        score_c = '0;
        for (int unsigned n = 0; n < NEUR_PER_CLASS; n++) begin
            score_c = score_c + SCORE_W'(cls_slice_c[n*POT_W +: POT_W]);
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        scan_idx_d     = scan_idx_q;
        best_idx_d     = best_idx_q;
        best_score_d   = best_score_q;
        output_cls_d   = output_cls;
        class_idx_d    = class_idx;
        no_winner_d    = no_winner;
        result_valid_d = 1'b0;
        busy_d         = busy;

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    snap_d       = potential_bus;
                    scan_idx_d   = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    busy_d       = 1'b1;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (system_state == SYS_IDLE) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    // Strictly greater keeps the lowest index on ties
                    if (score_c > best_score_q) begin
                        best_score_d = score_c;
                        best_idx_d   = scan_idx_q;
                    end
                    if (scan_idx_q == IDX_W'(NUM_CLASS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        scan_idx_d = scan_idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                class_idx_d    = best_idx_q;
                no_winner_d    = no_win_c;
                output_cls_d   = no_win_c ? '1 : ~(NUM_CLASS'(1) << best_idx_q);
                result_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prev_state_q <= SYS_IDLE;
            snap_q       <= '0;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            output_cls   <= '1;
            class_idx    <= '0;
            no_winner    <= 1'b1;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_state_q <= system_state;
            snap_q       <= snap_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            output_cls   <= output_cls_d;
            class_idx    <= class_idx_d;
            no_winner    <= no_winner_d;
            result_valid <= result_valid_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_wta_classifier.sv
// Self-checking bench for wta_classifier (4 classes x 2 neurons x 3 bits).
module tb_wta_classifier;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_SAMPLE   = 2'b01;
    localparam logic [1:0] ST_COMPLETE = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  system_state;
    logic [23:0] potential_bus;
    logic [3:0]  output_cls;
    logic [1:0]  class_idx;
    logic        no_winner;
    logic        result_valid;
    logic        busy;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] cls;
        logic       nw;
    } exp_t;

    typedef struct {
        string       name;
        logic [23:0] bus;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   checks    = 0;
    int   failures  = 0;
    int   pulse_cnt = 0;

    wta_classifier #(
        .NUM_CLASS     (4),
        .NEUR_PER_CLASS(2),
        .POT_W         (3),
        .MIN_SCORE     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .system_state (system_state),
        .potential_bus(potential_bus),
        .output_cls   (output_cls),
        .class_idx    (class_idx),
        .no_winner    (no_winner),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pack per-neuron potentials: a=class0, b=class1, c=class2, d=class3
    function automatic logic [23:0] mk(input int unsigned a0, a1, b0, b1, c0, c1, d0, d1);
        return {3'(d1), 3'(d0), 3'(c1), 3'(c0), 3'(b1), 3'(b0), 3'(a1), 3'(a0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every result pulse pops one expected result
    always @(negedge clk) begin
        exp_t e;
        if (result_valid === 1'b1) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result_valid actual=1 required=0 cls=%b idx=%0d", output_cls, class_idx);
            end else begin
                e = sb_q.pop_front();
                chk("class_idx", 32'(class_idx), 32'(e.idx));
                chk("output_cls", 32'(output_cls), 32'(e.cls));
                chk("no_winner", 32'(no_winner), 32'(e.nw));
            end
        end
    end

    // One classification: enter COMPLETE, measure latency, leave COMPLETE
    task automatic classify(input string name, input logic [23:0] bus, input exp_t e, input bit swap_after);
        int n;
        @(posedge clk); #1;
        system_state  = ST_COMPLETE;
        potential_bus = bus;
        sb_q.push_back(e);
        @(posedge clk); #1;
        chk({name, "_busy_start"}, 32'(busy), 32'd1);
        if (swap_after) potential_bus = mk(0, 0, 0, 0, 0, 0, 7, 7);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (result_valid === 1'b1) break;
        end
        chk({name, "_latency"}, 32'(n), 32'd5);
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({name, "_pulse_width"}, 32'(result_valid), 32'd0);
        system_state = ST_SAMPLE;
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_hold_cls"}, 32'(output_cls), 32'(e.cls));
    endtask

    initial begin
        int p0;
        vecs[0] = '{"basic",    mk(1, 2, 4, 5, 2, 3, 1, 1), '{idx: 2'd1, cls: 4'b1101, nw: 1'b0}};
        vecs[1] = '{"tie",      mk(5, 5, 1, 0, 3, 7, 0, 1), '{idx: 2'd0, cls: 4'b1110, nw: 1'b0}};
        vecs[2] = '{"low",      mk(3, 0, 1, 1, 0, 0, 2, 1), '{idx: 2'd0, cls: 4'b1111, nw: 1'b1}};
        vecs[3] = '{"max",      mk(7, 7, 7, 7, 7, 7, 7, 7), '{idx: 2'd0, cls: 4'b1110, nw: 1'b0}};
        vecs[4] = '{"zero",     mk(0, 0, 0, 0, 0, 0, 0, 0), '{idx: 2'd0, cls: 4'b1111, nw: 1'b1}};
        vecs[5] = '{"boundary", mk(2, 1, 1, 1, 0, 1, 2, 2), '{idx: 2'd3, cls: 4'b0111, nw: 1'b0}};

        rst_n         = 1'b0;
        system_state  = ST_IDLE;
        potential_bus = '0;
        #23;
        chk("reset_cls", 32'(output_cls), 32'hF);
        chk("reset_idx", 32'(class_idx), 32'd0);
        chk("reset_nw", 32'(no_winner), 32'd1);
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven vectors, each a fresh entry into COMPLETE
        for (int i = 0; i < 6; i++) begin
            classify(vecs[i].name, vecs[i].bus, vecs[i].exp, 1'b0);
        end

        // Input isolation: bus changes to favour class 3 after the start edge
        classify("isolation", vecs[0].bus, vecs[0].exp, 1'b1);

        // Holding COMPLETE produces exactly one result
        p0 = pulse_cnt;
        @(posedge clk); #1;
        system_state  = ST_COMPLETE;
        potential_bus = vecs[1].bus;
        sb_q.push_back(vecs[1].exp);
        repeat (20) @(posedge clk);
        #1;
        chk("hold_single_pulse", 32'(pulse_cnt - p0), 32'd1);
        system_state = ST_SAMPLE;
        repeat (2) @(posedge clk);

        // Abort: IDLE during the scan
        p0 = pulse_cnt;
        @(posedge clk); #1;
        system_state  = ST_COMPLETE;
        potential_bus = mk(0, 0, 0, 0, 0, 0, 7, 7);
        @(posedge clk); #1;
        chk("abort_busy_start", 32'(busy), 32'd1);
        @(posedge clk); #1;
        system_state = ST_IDLE;
        @(posedge clk); #1;
        chk("abort_busy_fall", 32'(busy), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        chk("abort_keep_cls", 32'(output_cls), 32'(4'b1110));
        chk("abort_keep_idx", 32'(class_idx), 32'd0);
        chk("abort_keep_nw", 32'(no_winner), 32'd0);

        // Asynchronous reset in the middle of a scan
        @(posedge clk); #1;
        system_state  = ST_COMPLETE;
        potential_bus = vecs[0].bus;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cls", 32'(output_cls), 32'hF);
        chk("rst_mid_nw", 32'(no_winner), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_idx", 32'(class_idx), 32'd0);
        system_state = ST_IDLE;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Recovery after reset
        classify("after_reset", vecs[5].bus, vecs[5].exp, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
